// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that sequences requester writes into one shared register.
// Optional macro REG_ARB_LOCK_EN adds a per-requester lock input for back-to-back bursts.
module reg_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0]      reg_q,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [WIDTH-1:0]      reg_d,
  output logic                  reg_en,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [WIDTH-1:0]      rdata
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    last, last_nxt, owner, owner_nxt, pick;
  logic             pick_vld, burst;
  logic [WIDTH-1:0] wd [NREQ];
  logic [WIDTH-1:0] reg_d_nxt, rdata_nxt;
  logic             reg_en_nxt, busy_nxt;
  logic [NREQ-1:0]  grant_nxt, ack_nxt;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign wd[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Scan from farthest to nearest after last so the nearest set request wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % NREQ)]) begin
        pick     = IW'((int'(last) + k) % NREQ);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef REG_ARB_LOCK_EN
  assign burst = lock[owner] & req[owner];
`else
  assign burst = 1'b0;
`endif

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = pick_vld ? WRITE : IDLE;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = burst ? WRITE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reg_d_nxt  = reg_d;
    reg_en_nxt = 1'b0;
    grant_nxt  = grant;
    ack_nxt    = '0;
    busy_nxt   = busy;
    rdata_nxt  = rdata;
    owner_nxt  = owner;
    last_nxt   = last;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (pick_vld) begin
          owner_nxt       = pick;
          grant_nxt[pick] = 1'b1;
          reg_d_nxt       = wd[pick];
          reg_en_nxt      = 1'b1;
          busy_nxt        = 1'b1;
        end else begin
          reg_d_nxt = '0;
          busy_nxt  = 1'b0;
        end
      end
      WRITE: ack_nxt = grant;
      ACK: begin
        // Register captured reg_d at the end of WRITE, so reg_q already holds the new value.
        rdata_nxt = reg_q;
        if (burst) begin
          reg_d_nxt  = wd[owner];
          reg_en_nxt = 1'b1;
        end else begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          last_nxt  = owner;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= LAST_RST;
      owner  <= '0;
      reg_d  <= '0;
      reg_en <= 1'b0;
      grant  <= '0;
      ack    <= '0;
      busy   <= 1'b0;
      rdata  <= '0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      owner  <= owner_nxt;
      reg_d  <= reg_d_nxt;
      reg_en <= reg_en_nxt;
      grant  <= grant_nxt;
      ack    <= ack_nxt;
      busy   <= busy_nxt;
      rdata  <= rdata_nxt;
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_reg_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [3:0]  req   = '0;
  logic [15:0] wdata = '0;
  logic [3:0]  reg_q = '0;
`ifdef REG_ARB_LOCK_EN
  logic [3:0]  lock  = '0;
`endif
  logic [3:0]  reg_d, grant, ack, rdata;
  logic        reg_en, busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] g;
    logic       en;
    logic [3:0] d;
    logic [3:0] a;
    logic       b;
    logic [3:0] rd;
  } exp_t;

  typedef struct {
    logic       r;
    logic [3:0] rq;
    exp_t       e;
    logic       cd;
  } vec_t;

  vec_t       tbl [21];
  exp_t       mq [$];
  int         m_last  = NREQ - 1;
  logic [3:0] m_rdata = '0;

  always #5 clk = ~clk;

  // The shared register driven only by the arbiter
  always @(posedge clk) if (reg_en) reg_q <= reg_d;

  reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .reg_q (reg_q),
`ifdef REG_ARB_LOCK_EN
    .lock  (lock),
`endif
    .reg_d (reg_d),
    .reg_en(reg_en),
    .grant (grant),
    .ack   (ack),
    .busy  (busy),
    .rdata (rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input logic chk_d);
    chk({tag, "_grant"}, 32'(grant),  32'(e.g));
    chk({tag, "_en"},    32'(reg_en), 32'(e.en));
    chk({tag, "_ack"},   32'(ack),    32'(e.a));
    chk({tag, "_busy"},  32'(busy),   32'(e.b));
    chk({tag, "_rdata"}, 32'(rdata),  32'(e.rd));
    if (chk_d) chk({tag, "_d"}, 32'(reg_d), 32'(e.d));
  endtask

  // Each won arbitration schedules a whole transaction: write cycle, ack cycle, completion.
  task automatic model_step(output exp_t e);
    int         w;
    logic [3:0] gg, dd;
    w = -1;
    if (rst) begin
      mq.delete();
      m_last  = NREQ - 1;
      m_rdata = '0;
      e = '{4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0};
    end else if (mq.size() != 0) begin
      e = mq.pop_front();
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx = (m_last + k) % NREQ;
        if (w < 0 && ((req >> idx) & 4'd1) != 4'd0) w = idx;
      end
      if (w < 0) begin
        e = '{4'h0, 1'b0, 4'h0, 4'h0, 1'b0, m_rdata};
      end else begin
        gg = 4'(1 << w);
        dd = 4'(wdata >> (4 * w));
        e  = '{gg, 1'b1, dd, 4'h0, 1'b1, m_rdata};
        mq.push_back('{gg, 1'b0, dd, gg, 1'b1, m_rdata});
        mq.push_back('{4'h0, 1'b0, dd, 4'h0, 1'b0, dd});
        m_rdata = dd;
        m_last  = w;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [3:0]  drop_nxt;
    logic [3:0]  grants [$];
    logic [15:0] hold;

    // w3=6 w2=B w1=9 w0=A; fields: rst, req, {grant, en, d, ack, busy, rdata}, check d
    tbl[0]  = '{1'b1, 4'b1111, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'h0}, 1'b1};
    tbl[1]  = '{1'b1, 4'b1111, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'h0}, 1'b1};
    tbl[2]  = '{1'b0, 4'b1111, '{4'b0001, 1'b1, 4'hA, 4'b0000, 1'b1, 4'h0}, 1'b1};
    tbl[3]  = '{1'b0, 4'b1111, '{4'b0001, 1'b0, 4'h0, 4'b0001, 1'b1, 4'h0}, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'hA}, 1'b0};
    tbl[5]  = '{1'b0, 4'b1110, '{4'b0010, 1'b1, 4'h9, 4'b0000, 1'b1, 4'hA}, 1'b1};
    tbl[6]  = '{1'b0, 4'b1110, '{4'b0010, 1'b0, 4'h0, 4'b0010, 1'b1, 4'hA}, 1'b0};
    tbl[7]  = '{1'b0, 4'b1110, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'h9}, 1'b0};
    tbl[8]  = '{1'b0, 4'b0100, '{4'b0100, 1'b1, 4'hB, 4'b0000, 1'b1, 4'h9}, 1'b1};
    tbl[9]  = '{1'b0, 4'b0100, '{4'b0100, 1'b0, 4'h0, 4'b0100, 1'b1, 4'h9}, 1'b0};
    tbl[10] = '{1'b0, 4'b0100, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'hB}, 1'b0};
    tbl[11] = '{1'b0, 4'b1000, '{4'b1000, 1'b1, 4'h6, 4'b0000, 1'b1, 4'hB}, 1'b1};
    tbl[12] = '{1'b0, 4'b1000, '{4'b1000, 1'b0, 4'h0, 4'b1000, 1'b1, 4'hB}, 1'b0};
    tbl[13] = '{1'b0, 4'b1000, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'h6}, 1'b0};
    tbl[14] = '{1'b0, 4'b1001, '{4'b0001, 1'b1, 4'hA, 4'b0000, 1'b1, 4'h6}, 1'b1};
    tbl[15] = '{1'b0, 4'b1001, '{4'b0001, 1'b0, 4'h0, 4'b0001, 1'b1, 4'h6}, 1'b0};
    tbl[16] = '{1'b0, 4'b1001, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'hA}, 1'b0};
    tbl[17] = '{1'b0, 4'b1000, '{4'b1000, 1'b1, 4'h6, 4'b0000, 1'b1, 4'hA}, 1'b1};
    tbl[18] = '{1'b0, 4'b1000, '{4'b1000, 1'b0, 4'h0, 4'b1000, 1'b1, 4'hA}, 1'b0};
    tbl[19] = '{1'b0, 4'b1000, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'h6}, 1'b0};
    tbl[20] = '{1'b0, 4'b0000, '{4'b0000, 1'b0, 4'h0, 4'b0000, 1'b0, 4'h6}, 1'b0};

    wdata = 16'h6B9A;
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].r;
      req = tbl[i].rq;
      step();
      check_outputs($sformatf("row%0d", i), tbl[i].e, tbl[i].cd);
    end

    // All requesting: each drops req after its ack and re-raises one cycle later
    rst = 1'b1; req = '0; step(); step();
    rst = 1'b0; req = 4'b1111; drop_nxt = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (reg_en) grants.push_back(grant);
      req      = (~req) | (req & ~drop_nxt);
      drop_nxt = ack;
    end
    chk("fair_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk($sformatf("fair_grant%0d", i), 32'(grants[i]), 32'(1 << i));

    // Reset landing on the WRITE cycle aborts without ack
    rst = 1'b1; req = '0; step();
    rst = 1'b0; req = 4'b0100; step();
    chk("mid_write_grant", 32'(grant), 32'b0100);
    chk("mid_write_en", 32'(reg_en), 32'd1);
    rst = 1'b1; step();
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_en", 32'(reg_en), 32'd0);
    rst = 1'b0; req = 4'b0101; step();
    chk("restart_grant", 32'(grant), 32'b0001);
    step();
    chk("restart_ack", 32'(ack), 32'b0001);
    step();
    chk("restart_rdata", 32'(rdata), 32'hA);
    req = '0; step();

`ifdef REG_ARB_LOCK_EN
    rst = 1'b1; step(); rst = 1'b0;
    wdata = 16'hF010; req = 4'b1010; lock = 4'b0010; step();
    chk("lk_grant1", 32'(grant), 32'b0010);
    chk("lk_en1", 32'(reg_en), 32'd1);
    chk("lk_d1", 32'(reg_d), 32'h1);
    wdata = 16'hF020; step();
    chk("lk_ack1", 32'(ack), 32'b0010);
    step();
    chk("lk_grant2", 32'(grant), 32'b0010);
    chk("lk_en2", 32'(reg_en), 32'd1);
    chk("lk_d2", 32'(reg_d), 32'h2);
    wdata = 16'hF030; step();
    chk("lk_ack2", 32'(ack), 32'b0010);
    step();
    chk("lk_en3", 32'(reg_en), 32'd1);
    chk("lk_d3", 32'(reg_d), 32'h3);
    lock = '0; step();
    chk("lk_ack3", 32'(ack), 32'b0010);
    step();
    chk("lk_end_busy", 32'(busy), 32'd0);
    chk("lk_end_rdata", 32'(rdata), 32'h3);
    req = 4'b1000; step();
    chk("lk_next_grant", 32'(grant), 32'b1000);
    chk("lk_next_d", 32'(reg_d), 32'hF);
    step(); step(); req = '0; step();
`endif

    // Randomized protocol-following requesters against the model
    req = '0; wdata = '0; drop_nxt = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = (c < 2) || ($urandom_range(0, 249) == 0);
      step();
      model_step(e);
      check_outputs($sformatf("rnd%0d", c), e, e.en);
      chk($sformatf("rnd%0d_onehot", c), 32'($onehot0(grant)), 32'd1);
      chk($sformatf("rnd%0d_subset", c), 32'((ack & ~grant) == 4'd0), 32'd1);
      req   = req & ~drop_nxt;
      hold  = {{4{req[3]}}, {4{req[2]}}, {4{req[1]}}, {4{req[0]}}};
      req   = req | (4'($urandom) & 4'($urandom) & ~drop_nxt);
      wdata = (wdata & hold) | (16'($urandom) & ~hold);
      drop_nxt = e.a;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
